// File: rtl/twobit.sv
// Two-bit ripple subtractor (two full-subtractor cells) with registered outputs; ovf port via TWOBIT_OVF_EN.
// Latency 1 cycle, one result per accepted cycle; no backpressure, outputs hold while in_valid is low.
module twobit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       bin,
  input  logic       in_valid,
  output logic [1:0] d,
  output logic       bout,
  output logic       out_valid
`ifdef TWOBIT_OVF_EN
  ,
  output logic       ovf
`endif
);

  logic [2:0] br;
  logic [1:0] diff;

  assign br[0] = bin;

  for (genvar i = 0; i < 2; i++) begin : g_cell
    assign diff[i]  = a[i] ^ b[i] ^ br[i];
    assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d         <= 2'b00;
      bout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        d    <= diff;
        bout <= br[2];
      end
    end
  end

`ifdef TWOBIT_OVF_EN
  // Signed overflow: borrow into the sign cell differs from borrow out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= br[1] ^ br[2];
    end
  end
`endif

endmodule

// File: tb/tb_twobit.sv
// Self-checking bench for twobit: random, exhaustive and directed stimulus against an arithmetic model.
module tb_twobit;

  logic       clk;
  logic       rst_n;
  logic [1:0] a;
  logic [1:0] b;
  logic       bin;
  logic       in_valid;
  logic [1:0] d;
  logic       bout;
  logic       out_valid;
`ifdef TWOBIT_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: what the outputs should currently show.
  logic [1:0] exp_d;
  logic       exp_bout;
  logic       exp_vld;
  logic       exp_ovf;

  twobit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .in_valid  (in_valid),
    .d         (d),
    .bout      (bout),
    .out_valid (out_valid)
`ifdef TWOBIT_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".d"}, {2'b00, d}, {2'b00, exp_d});
    chk({tag, ".bout"}, {3'b000, bout}, {3'b000, exp_bout});
    chk({tag, ".out_valid"}, {3'b000, out_valid}, {3'b000, exp_vld});
`ifdef TWOBIT_OVF_EN
    chk({tag, ".ovf"}, {3'b000, ovf}, {3'b000, exp_ovf});
`endif
  endtask

  // Arithmetic model: {bout,d} = (a - b - bin) mod 8; ovf when signed result leaves -2..1.
  task automatic model(input int ia, input int ib, input int ibin);
    int diff;
    int sa;
    int sb;
    int sres;
    diff = ia - ib - ibin;
    if (diff < 0) diff = diff + 8;
    exp_d    = 2'(diff % 4);
    exp_bout = (ia < ib + ibin);
    sa   = (ia >= 2) ? ia - 4 : ia;
    sb   = (ib >= 2) ? ib - 4 : ib;
    sres = sa - sb - ibin;
    exp_ovf = (sres < -2) || (sres > 1);
  endtask

  task automatic step(input int ia, input int ib, input int ibin, input logic vld, input string tag);
    @(negedge clk);
    a        = 2'(ia);
    b        = 2'(ib);
    bin      = 1'(ibin);
    in_valid = vld;
    @(posedge clk);
    #1;
    if (vld) model(ia, ib, ibin);
    exp_vld = vld;
    check_outputs(tag);
  endtask

  task automatic model_reset();
    exp_d    = 2'b00;
    exp_bout = 1'b0;
    exp_vld  = 1'b0;
    exp_ovf  = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    a        = 2'd3;
    b        = 2'd1;
    bin      = 1'b1;
    in_valid = 1'b1;
    model_reset();

    // Reset holds outputs low even with clock running and in_valid high.
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // Random traffic with random in_valid gaps.
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
           1'($urandom_range(0, 1)), "random");
    end

    // Exhaustive sweep, back-to-back.
    for (int i = 0; i < 32; i++) begin
      step((i >> 3) & 3, (i >> 1) & 3, i & 1, 1'b1, "sweep");
    end

    // Directed operands and boundaries.
    step(3, 1, 0, 1'b1, "dir_3_1_0");
    chk("dir_3_1_0.d_const", {2'b00, d}, 4'd2);
    step(0, 0, 1, 1'b1, "dir_0_0_1");
    chk("dir_0_0_1.d_const", {2'b00, d}, 4'd3);
    step(1, 3, 1, 1'b1, "dir_1_3_1");
    chk("dir_1_3_1.d_const", {2'b00, d}, 4'd1);
    step(0, 3, 1, 1'b1, "max_borrow");
    chk("max_borrow.bout_const", {3'b000, bout}, 4'd1);
    step(3, 0, 0, 1'b1, "max_result");
    chk("max_result.d_const", {2'b00, d}, 4'd3);

    // Hold: accept once, then idle with toggling operands.
    step(2, 1, 0, 1'b1, "hold_accept");
    for (int i = 0; i < 3; i++) begin
      step($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), 1'b0, "hold_idle");
      chk("hold_idle.d_const", {2'b00, d}, 4'd1);
    end

`ifdef TWOBIT_OVF_EN
    step(1, 2, 0, 1'b1, "ovf_1_2");
    chk("ovf_1_2.ovf_const", {3'b000, ovf}, 4'd1);
    step(2, 1, 0, 1'b1, "ovf_2_1");
    chk("ovf_2_1.ovf_const", {3'b000, ovf}, 4'd1);
    step(1, 1, 0, 1'b1, "ovf_1_1");
    chk("ovf_1_1.ovf_const", {3'b000, ovf}, 4'd0);
`endif

    // Mid-cycle asynchronous reset with a pending operand discarded.
    step(0, 1, 0, 1'b1, "pre_reset");
    chk("pre_reset.d_const", {2'b00, d}, 4'd3);
    #2;
    a        = 2'd3;
    b        = 2'd0;
    bin      = 1'b0;
    in_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(posedge clk);
    #1;
    check_outputs("reset_discard");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step(1, 0, 0, 1'b1, "post_reset");
    chk("post_reset.d_const", {2'b00, d}, 4'd1);
    step(1, 0, 0, 1'b0, "post_reset_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/twobit.md
TWOBIT -- requirements
Module: twobit

Interface
- REQ-001: Parameters: none; operand width is fixed at 2 bits.
- REQ-002: clk  input  1  single clock; all state updates on the rising edge.
- REQ-003: rst_n  input  1  asynchronous, active-low reset.
- REQ-004: a  input  2  minuend, unsigned.
- REQ-005: b  input  2  subtrahend, unsigned.
- REQ-006: bin  input  1  borrow-in, weight 1.
- REQ-007: in_valid  input  1  qualifies a, b and bin for capture this cycle.
- REQ-008: d  output  2  registered difference.
- REQ-009: bout  output  1  registered borrow-out.
- REQ-010: out_valid  output  1  high for exactly one cycle per accepted operation.
- REQ-011: ovf  output  1  registered signed-overflow flag; the port exists only when TWOBIT_OVF_EN is defined.

Function
- REQ-012: Datapath SHALL be two cascaded 1-bit full-subtractor cells.
  - Cell i: d_i = a_i ^ b_i ^ br_i.
  - Cell i: br_(i+1) = (~a_i & b_i) | (~(a_i ^ b_i) & br_i).
  - br_0 = bin.
- REQ-013: Resulting arithmetic: d = (a - b - bin) mod 4; bout = 1 iff a < b + bin (unsigned); equivalently {bout,d} = (a - b - bin) mod 8.
- REQ-014: Latency SHALL be exactly 1 cycle: operands sampled at edge N with in_valid=1 appear on d/bout with out_valid=1 after edge N.
- REQ-015: With in_valid=1 on consecutive cycles, one result per cycle with no bubbles; no backpressure input exists.
- REQ-016: With in_valid=0 at an edge: d, bout and ovf hold their previous values, and out_valid deasserts after that edge.
- REQ-017: Operands changing while in_valid=0 SHALL NOT affect any output.
- REQ-018: Boundary: a=0, b=3, bin=1 yields d=0, bout=1 (maximum borrow); a=3, b=0, bin=0 yields d=3, bout=0.
- REQ-019: No internal state beyond the output registers; each result depends only on the operands of its own capture cycle.

Reset
- REQ-020: While rst_n=0, regardless of clk: d=0, bout=0, out_valid=0 and (if present) ovf=0.
- REQ-021: Reset asserted mid-stream SHALL discard any result pending capture.
- REQ-022: Operation resumes on the first rising edge after rst_n deasserts, with the same 1-cycle latency.

Configuration
- REQ-023: Macro TWOBIT_OVF_EN:
  - Defined: port ovf exists and is registered alongside d.
  - ovf = br_1 ^ br_2, i.e. a and b read as 2-bit two's complement (range -2..1) and the result d does not fit in that range.
  - Not defined: no ovf port and no ovf logic; all other behaviour identical.

Verification
- REQ-024: Exhaustive sweep of all 32 {a,b,bin} combinations, one per cycle with in_valid=1 -> each result matches REQ-013 one cycle later, and out_valid stays high throughout.
- REQ-025: Directed operands:
  - a=3, b=1, bin=0 -> d=2, bout=0.
  - a=0, b=0, bin=1 -> d=3, bout=1.
  - a=1, b=3, bin=1 -> d=1, bout=1.
- REQ-026: Accept a=2, b=1, bin=0, then hold in_valid=0 for 3 cycles while toggling operands -> d stays 1, bout stays 0, out_valid is high for one cycle only.
- REQ-027: Assert rst_n=0 between clock edges while d=3 and bout=1 -> all outputs go to 0 immediately; the first post-reset accept of a=1, b=0, bin=0 yields d=1 one cycle later.
- REQ-028: With TWOBIT_OVF_EN defined:
  - a=1, b=2, bin=0 -> d=3, ovf=1.
  - a=2, b=1, bin=0 -> d=1, ovf=1.
  - a=1, b=1, bin=0 -> d=0, ovf=0.
  - Without the macro, the bench compiles with no ovf port.
